// File: rtl/mycpu_pkg.sv
// Shared CPU types: ALU operation codes and flag bit positions in the {Z,N,C,V} flag word.
package mycpu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } alu_op_t;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_Z] = z;
      f[FLAG_N] = n;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Bit 0 is consumed on the start edge, so done_o rises DW-1 edges later.
module mul_iter #(
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   output logic            done_o,
   output logic [2*DW-1:0] p_o
);

   localparam int CW = $clog2(DW + 1);

   logic [2*DW-1:0] acc_q, acc_d;
   logic [2*DW-1:0] mcand_q, mcand_d;
   logic [DW-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         acc_d    = b_i[0] ? {{DW{1'b0}}, a_i} : '0;
         mcand_d  = {{DW{1'b0}}, a_i} << 1;
         mplier_d = b_i >> 1;
         cnt_d    = CW'(1);
      end else if (cnt_q != '0 && cnt_q != CW'(DW)) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign done_o = (cnt_q == CW'(DW));
   assign p_o    = acc_q;

endmodule

// File: rtl/alu.sv
// Register-bank ALU: single-cycle logic/arith ops, iterative MUL, one-cycle write strobe in DONE.
// Results, write address and flags are held from one DONE until the next.
module alu
   import mycpu_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_in,
   input  alu_op_t       op_in,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic [3:0]    dst_in,
   output logic          busy_out,
   output logic [DW-1:0] d_out,
   output logic          rw_out,
   output logic [3:0]    wr_addr_out,
   output logic [3:0]    flags_out
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   d_q;
   logic [3:0]      wr_addr_q, dst_q, flags_q;
   logic            mul_start, mul_done, fast_load, mul_load;
   logic [2*DW-1:0] mul_p;

   logic [DW:0]     wide;
   logic [DW-1:0]   res;
   logic            c_flag, v_flag;
   logic [3:0]      sh;

   mul_iter #(.DW(DW)) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start_i(mul_start),
      .a_i    (a_in),
      .b_i    (b_in),
      .done_o (mul_done),
      .p_o    (mul_p)
   );

   always_comb begin
      state_d   = state_q;
      mul_start = 1'b0;
      fast_load = 1'b0;
      mul_load  = 1'b0;
      case (state_q)
         S_IDLE: if (start_in) begin
            if (op_in == OP_MUL) begin
               state_d   = S_MUL;
               mul_start = 1'b1;
            end else begin
               state_d   = S_DONE;
               fast_load = 1'b1;
            end
         end
         S_MUL: if (mul_done) begin
            state_d  = S_DONE;
            mul_load = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Single-cycle datapath works straight off the inputs on the accepting edge.
   always_comb begin
      wide   = '0;
      res    = '0;
      c_flag = 1'b0;
      v_flag = 1'b0;
      sh     = b_in[3:0];
      case (op_in)
         OP_ADD: begin
            wide   = {1'b0, a_in} + {1'b0, b_in};
            res    = wide[DW-1:0];
            c_flag = wide[DW];
            v_flag = (a_in[DW-1] == b_in[DW-1]) && (res[DW-1] != a_in[DW-1]);
         end
         OP_SUB: begin
            res    = a_in - b_in;
            c_flag = (a_in < b_in);
            v_flag = (a_in[DW-1] != b_in[DW-1]) && (res[DW-1] != a_in[DW-1]);
         end
         OP_AND: res = a_in & b_in;
         OP_OR:  res = a_in | b_in;
         OP_XOR: res = a_in ^ b_in;
         OP_SHL: begin
            wide   = {1'b0, a_in} << sh;
            res    = wide[DW-1:0];
            c_flag = wide[DW];
         end
         OP_SHR: begin
            wide   = {a_in, 1'b0} >> sh;
            res    = wide[DW:1];
            c_flag = wide[0];
         end
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         d_q       <= '0;
         wr_addr_q <= '0;
         dst_q     <= '0;
         flags_q   <= '0;
      end else begin
         state_q <= state_d;
         if (mul_start) dst_q <= dst_in;
         if (fast_load) begin
            d_q       <= res;
            wr_addr_q <= dst_in;
            flags_q   <= pack_flags(res == '0, res[DW-1], c_flag, v_flag);
         end else if (mul_load) begin
            d_q       <= mul_p[DW-1:0];
            wr_addr_q <= dst_q;
            flags_q   <= pack_flags(mul_p[DW-1:0] == '0, mul_p[DW-1],
                                    |mul_p[2*DW-1:DW], 1'b0);
         end
      end
   end

   assign busy_out    = (state_q != S_IDLE);
   assign rw_out      = (state_q == S_DONE);
   assign d_out       = d_q;
   assign wr_addr_out = wr_addr_q;
   assign flags_out   = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: hand-computed vectors for every op, MUL timing, reset abort.
module tb_alu;
   import mycpu_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_in;
   alu_op_t       op_in;
   logic [15:0]   a_in, b_in;
   logic [3:0]    dst_in;
   logic          busy_out, rw_out;
   logic [15:0]   d_out;
   logic [3:0]    wr_addr_out, flags_out;

   int n_checks = 0;
   int n_fail   = 0;

   alu #(.DW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_in   (start_in),
      .op_in      (op_in),
      .a_in       (a_in),
      .b_in       (b_in),
      .dst_in     (dst_in),
      .busy_out   (busy_out),
      .d_out      (d_out),
      .rw_out     (rw_out),
      .wr_addr_out(wr_addr_out),
      .flags_out  (flags_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one single-cycle op, check the DONE cycle and the following idle cycle.
   task automatic do_op(input string tag, input alu_op_t op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] dst,
                        input logic [15:0] exp_d, input logic [3:0] exp_f);
      op_in = op; a_in = a; b_in = b; dst_in = dst; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check({tag, "_rw"},    rw_out,      1);
      check({tag, "_busy"},  busy_out,    1);
      check({tag, "_d"},     d_out,       exp_d);
      check({tag, "_addr"},  wr_addr_out, dst);
      check({tag, "_flags"}, flags_out,   exp_f);
      tick();
      check({tag, "_rw_off"}, rw_out,   0);
      check({tag, "_idle"},   busy_out, 0);
      check({tag, "_hold"},   d_out,    exp_d);
   endtask

   initial begin
      logic rw_seen;
      rst_n = 1'b0; start_in = 1'b1; op_in = OP_ADD; a_in = 16'h1; b_in = 16'h1; dst_in = 4'h1;
      tick();
      tick();
      check("rst_busy",  busy_out,    0);
      check("rst_rw",    rw_out,      0);
      check("rst_d",     d_out,       0);
      check("rst_addr",  wr_addr_out, 0);
      check("rst_flags", flags_out,   0);
      start_in = 1'b0;
      rst_n    = 1'b1;
      tick();

      //            tag        op      a         b         dst   d         ZNCV
      do_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 4'd3, 16'h8000, 4'b0101);
      do_op("sub_zero", OP_SUB, 16'h0005, 16'h0005, 4'd9, 16'h0000, 4'b1000);
      do_op("sub_brw",  OP_SUB, 16'h0001, 16'h0002, 4'd1, 16'hFFFF, 4'b0110);
      do_op("shl_c",    OP_SHL, 16'h8001, 16'h0001, 4'd2, 16'h0002, 4'b0010);
      do_op("shr_0",    OP_SHR, 16'h0001, 16'h0000, 4'd4, 16'h0001, 4'b0000);
      do_op("shr_15",   OP_SHR, 16'h8000, 16'h000F, 4'd5, 16'h0001, 4'b0000);
      do_op("shr_c",    OP_SHR, 16'h0003, 16'h0001, 4'd6, 16'h0001, 4'b0010);
      do_op("and",      OP_AND, 16'hF0F0, 16'h0FF0, 4'd7, 16'h00F0, 4'b0000);
      do_op("or",       OP_OR,  16'h8000, 16'h0001, 4'd8, 16'h8001, 4'b0100);
      do_op("xor",      OP_XOR, 16'hAAAA, 16'hAAAA, 4'd15, 16'h0000, 4'b1000);
      do_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 4'd10, 16'h0000, 4'b1010);
      do_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 4'd11, 16'h7FFF, 4'b0001);

      // MUL: busy for 17 cycles, strobe only in the 17th, second start ignored.
      op_in = OP_MUL; a_in = 16'h0100; b_in = 16'h0101; dst_in = 4'd12; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         check("mul_busy", busy_out, 1);
         check("mul_rw",   rw_out,   (k == 17) ? 1 : 0);
         if (k == 1) check("mul_hold_prev", d_out, 16'h7FFF);
         if (k == 5) begin
            start_in = 1'b1; op_in = OP_ADD; a_in = 16'h0001; b_in = 16'h0001; dst_in = 4'd2;
         end
         if (k == 6) start_in = 1'b0;
         if (k == 17) begin
            check("mul_d",     d_out,       16'h0100);
            check("mul_flags", flags_out,   4'b0010);
            check("mul_addr",  wr_addr_out, 4'd12);
         end
         tick();
      end
      check("mul_end_busy", busy_out, 0);
      check("mul_end_rw",   rw_out,   0);
      check("mul_end_hold", d_out,    16'h0100);
      tick();
      check("mul_no_extra", rw_out, 0);

      // Reset in the middle of a MUL aborts it with no later strobe.
      op_in = OP_MUL; a_in = 16'h0003; b_in = 16'h0005; dst_in = 4'd4; start_in = 1'b1;
      tick();
      start_in = 1'b0;
      repeat (7) tick();
      check("abort_pre_busy", busy_out, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy",  busy_out,    0);
      check("abort_rw",    rw_out,      0);
      check("abort_d",     d_out,       0);
      check("abort_addr",  wr_addr_out, 0);
      check("abort_flags", flags_out,   0);
      tick();
      rst_n = 1'b1;
      rw_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rw_out || busy_out) rw_seen = 1'b1;
      end
      check("abort_no_rw", rw_seen, 0);

      // Start held during reset is ignored; first edge after release accepts it.
      rst_n = 1'b0;
      op_in = OP_ADD; a_in = 16'h0002; b_in = 16'h0003; dst_in = 4'd5; start_in = 1'b1;
      tick();
      check("rst_ignore_start", busy_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_in = 1'b0;
      check("post_rst_rw",    rw_out,      1);
      check("post_rst_d",     d_out,       16'h0005);
      check("post_rst_addr",  wr_addr_out, 4'd5);
      check("post_rst_flags", flags_out,   4'b0000);
      tick();
      check("post_rst_idle", busy_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
